regwb_seq: RTL and testbench



---
 rtl/regwb_pkg.sv | 18 +
 rtl/regwb_fifo.sv | 65 ++++++
 rtl/regwb_seq.sv | 154 +++++++++++++++
 tb/tb_regwb_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/regwb_pkg.sv
// Shared widths and the queued-write entry type for the register-bank write-back sequencer.
package regwb_pkg;

    localparam int REG_AW = 3;
    localparam int REG_DW = 16;
    localparam int NREGS  = 8;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } regwb_entry_t;

    // Pointer-based circular buffers need one extra count bit to tell full from empty.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/regwb_fifo.sv
// Circular write-request FIFO: two ordered push ports, one pop port, and an age-ordered view
// of all entries (index 0 = head) so callers can scan pending destinations.
module regwb_fifo
    import regwb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = count_width(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push0_i,
    input  regwb_entry_t push0_entry_i,
    input  logic         push1_i,
    input  regwb_entry_t push1_entry_i,
    input  logic         pop_i,
    output logic [CW-1:0] count_o,
    output regwb_entry_t age_entry_o [DEPTH],
    output logic [DEPTH-1:0] age_valid_o
);

    regwb_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_p1;
    logic [PW-1:0] push1_idx;

    assign wr_ptr_p1 = wr_ptr_q + PW'(1);
    // Port 1 lands behind port 0 when both push, keeping acceptance order.
    assign push1_idx = push0_i ? wr_ptr_p1 : wr_ptr_q;

    assign wr_ptr_d = wr_ptr_q + PW'(push0_i) + PW'(push1_i);
    assign rd_ptr_d = rd_ptr_q + PW'(pop_i);
    assign count_d  = count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);

    // NOTE: storage has no reset; validity comes solely from count_q, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (push0_i) mem_q[wr_ptr_q]  <= push0_entry_i;
        if (push1_i) mem_q[push1_idx] <= push1_entry_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            age_entry_o[k] = mem_q[rd_ptr_q + PW'(k)];
            age_valid_o[k] = (CW'(k) < count_q);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/regwb_seq.sv
// Write-back sequencer for the 8x16 register bank: merges ALU (A) and load (B) writes through a
// FIFO, drains one write per clock, and publishes a pending scoreboard. Define REGWB_BYPASS_EN
// to enable the bypass lookup on ra1/ra2; otherwise the fwd* outputs are tied to zero.
module regwb_seq
    import regwb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = REG_DW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [REG_AW-1:0] a_addr,
    input  logic [DW-1:0]     a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [REG_AW-1:0] b_addr,
    input  logic [DW-1:0]     b_data,
    output logic [REG_AW-1:0] Wa,
    output logic [DW-1:0]     Wd,
    output logic              Wen,
    output logic [NREGS-1:0]  pending,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [DW-1:0]     fwd1_data,
    output logic [DW-1:0]     fwd2_data
);

    localparam int CW = count_width(DEPTH);

    logic [CW-1:0]     count;
    regwb_entry_t      fifo_entry [DEPTH];
    logic [DEPTH-1:0]  fifo_valid;
    regwb_entry_t      a_entry, b_entry;
    logic              a_nz, b_nz;
    logic              a_push, b_push;
    logic              pop;

    logic              rdy_en_q;
    logic              wen_q, wen_d;
    logic [REG_AW-1:0] wa_q, wa_d;
    logic [DW-1:0]     wd_q, wd_d;

    assign a_nz = (a_addr != '0);
    assign b_nz = (b_addr != '0);

    // Readies hold low through reset and the first cycle after release.
    assign a_ready = rdy_en_q && (count < CW'(DEPTH));
    assign b_ready = rdy_en_q && ((count + CW'(a_valid && a_nz)) < CW'(DEPTH));

    // R0 writes are handshaken but never enter the queue.
    assign a_push = a_valid && a_ready && a_nz;
    assign b_push = b_valid && b_ready && b_nz;
    assign pop    = (count != '0);

    assign a_entry = '{addr: a_addr, data: REG_DW'(a_data)};
    assign b_entry = '{addr: b_addr, data: REG_DW'(b_data)};

    regwb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push0_i      (a_push),
        .push0_entry_i(a_entry),
        .push1_i      (b_push),
        .push1_entry_i(b_entry),
        .pop_i        (pop),
        .count_o      (count),
        .age_entry_o  (fifo_entry),
        .age_valid_o  (fifo_valid)
    );

    always_comb begin
        wen_d = pop;
        wa_d  = wa_q;
        wd_d  = wd_q;
        if (pop) begin
            wa_d = fifo_entry[0].addr;
            wd_d = DW'(fifo_entry[0].data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q <= 1'b0;
            wen_q    <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            wen_q    <= wen_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
        end
    end

    assign Wen = wen_q;
    assign Wa  = wa_q;
    assign Wd  = wd_q;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        pending = '0;
        if (wen_q) pending[wa_q] = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            if (fifo_valid[k]) pending[fifo_entry[k].addr] = 1'b1;
        end
        pending[0] = 1'b0;
    end

`ifdef REGWB_BYPASS_EN
    // Output stage is older than every queued entry; later FIFO matches override it.
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        if (ra1 != '0) begin
            if (wen_q && (wa_q == ra1)) begin
                fwd1_hit  = 1'b1;
                fwd1_data = wd_q;
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (fifo_valid[k] && (fifo_entry[k].addr == ra1)) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = DW'(fifo_entry[k].data);
                end
            end
        end
        if (ra2 != '0) begin
            if (wen_q && (wa_q == ra2)) begin
                fwd2_hit  = 1'b1;
                fwd2_data = wd_q;
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (fifo_valid[k] && (fifo_entry[k].addr == ra2)) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = DW'(fifo_entry[k].data);
                end
            end
        end
    end
`else
    logic unused_ra;
    assign unused_ra = ^{ra1, ra2};
    assign fwd1_hit  = 1'b0;
    assign fwd2_hit  = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_regwb_seq.sv
// Directed bench for regwb_seq: reset, single write, same-cycle A/B, sustained back-to-back
// traffic, R0 drop, reset mid-drain and bypass lookup (REGWB_BYPASS_EN aware).
module tb_regwb_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [2:0]  a_addr, b_addr, Wa, ra1, ra2;
    logic [15:0] a_data, b_data, Wd, fwd1_data, fwd2_data;
    logic        Wen, fwd1_hit, fwd2_hit;
    logic [7:0]  pending;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t         log_q[$];
    wr_t         exp_q[$];
    logic [15:0] regbank [8];

`ifdef REGWB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regwb_seq #(.DEPTH(4), .DW(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .Wa       (Wa),
        .Wd       (Wd),
        .Wen      (Wen),
        .pending  (pending),
        .ra1      (ra1),
        .ra2      (ra2),
        .fwd1_hit (fwd1_hit),
        .fwd2_hit (fwd2_hit),
        .fwd1_data(fwd1_data),
        .fwd2_data(fwd2_data)
    );

    always #5 clk = ~clk;

    // Register-bank model: captures each strobe just after the edge that launched it.
    always @(posedge clk) begin
        #1;
        if (Wen) begin
            log_q.push_back('{a: Wa, d: Wd});
            regbank[Wa] = Wd;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        ra1 = 3'd3; ra2 = 3'd5;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++; if (Wen !== 1'b0) begin tests_failed++; $display("FAIL reset_wen: got %b expected 0", Wen); end
        tests_run++; if (Wa !== 3'd0) begin tests_failed++; $display("FAIL reset_wa: got %0d expected 0", Wa); end
        tests_run++; if (Wd !== 16'h0) begin tests_failed++; $display("FAIL reset_wd: got %h expected 0000", Wd); end
        tests_run++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got a=%b b=%b expected 0 0", a_ready, b_ready); end
        tests_run++; if (pending !== 8'h00) begin tests_failed++; $display("FAIL reset_pending: got %h expected 00", pending); end
        tests_run++; if ({fwd1_hit, fwd2_hit, fwd1_data, fwd2_data} !== 34'h0) begin tests_failed++; $display("FAIL reset_fwd: got %b%b %h %h expected all 0", fwd1_hit, fwd2_hit, fwd1_data, fwd2_data); end
        rst_n = 1'b1;
        tick();
        tests_run++; if (a_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_ready: got %b expected 1", a_ready); end
        for (int r = 0; r < 8; r++) regbank[r] = '0;
    endtask

    task automatic test_single_write();
        log_q.delete();
        a_valid = 1'b1; a_addr = 3'd3; a_data = 16'h1234;
        #1;
        tests_run++; if (a_ready !== 1'b1) begin tests_failed++; $display("FAIL single_ready: got %b expected 1", a_ready); end
        tick();
        idle_inputs();
        tests_run++; if (Wen !== 1'b0) begin tests_failed++; $display("FAIL single_early_wen: got %b expected 0", Wen); end
        tests_run++; if (pending !== 8'h08) begin tests_failed++; $display("FAIL single_pending_q: got %h expected 08", pending); end
        tick();
        tests_run++; if ({Wen, Wa, Wd} !== {1'b1, 3'd3, 16'h1234}) begin tests_failed++; $display("FAIL single_write: got wen=%b wa=%0d wd=%h expected 1 3 1234", Wen, Wa, Wd); end
        tests_run++; if (pending !== 8'h08) begin tests_failed++; $display("FAIL single_pending_out: got %h expected 08", pending); end
        tick();
        tests_run++; if (Wen !== 1'b0 || pending !== 8'h00) begin tests_failed++; $display("FAIL single_done: got wen=%b pending=%h expected 0 00", Wen, pending); end
        tests_run++; if (log_q.size() != 1) begin tests_failed++; $display("FAIL single_count: got %0d writes expected 1", log_q.size()); end
    endtask

    task automatic test_same_cycle();
        log_q.delete();
        a_valid = 1'b1; a_addr = 3'd2; a_data = 16'h00AA;
        b_valid = 1'b1; b_addr = 3'd2; b_data = 16'h00BB;
        #1;
        tests_run++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin tests_failed++; $display("FAIL same_ready: got a=%b b=%b expected 1 1", a_ready, b_ready); end
        tick();
        idle_inputs();
        tests_run++; if (pending !== 8'h04) begin tests_failed++; $display("FAIL same_pending: got %h expected 04", pending); end
        tick();
        tests_run++; if ({Wen, Wa, Wd} !== {1'b1, 3'd2, 16'h00AA}) begin tests_failed++; $display("FAIL same_first: got wen=%b wa=%0d wd=%h expected 1 2 00aa", Wen, Wa, Wd); end
        tick();
        tests_run++; if ({Wen, Wa, Wd} !== {1'b1, 3'd2, 16'h00BB}) begin tests_failed++; $display("FAIL same_second: got wen=%b wa=%0d wd=%h expected 1 2 00bb", Wen, Wa, Wd); end
        tick();
        tests_run++; if (Wen !== 1'b0) begin tests_failed++; $display("FAIL same_idle: got %b expected 0", Wen); end
        tests_run++; if (regbank[2] !== 16'h00BB) begin tests_failed++; $display("FAIL same_readback: got %h expected 00bb", regbank[2]); end
    endtask

    task automatic test_back_to_back();
        int mcount = 0;
        bit exp_a, exp_b;
        log_q.delete();
        exp_q.delete();
        for (int i = 0; i < 12; i++) begin
            a_valid = 1'b1; a_addr = 3'(1 + (i % 7));       a_data = 16'hA000 + 16'(i);
            b_valid = 1'b1; b_addr = 3'(1 + ((i + 3) % 7)); b_data = 16'hB000 + 16'(i);
            #1;
            exp_a = (mcount < 4);
            exp_b = (mcount + 1 < 4);
            tests_run++; if (a_ready !== exp_a) begin tests_failed++; $display("FAIL b2b_a_ready[%0d]: got %b expected %b", i, a_ready, exp_a); end
            tests_run++; if (b_ready !== exp_b) begin tests_failed++; $display("FAIL b2b_b_ready[%0d]: got %b expected %b", i, b_ready, exp_b); end
            if (exp_a) exp_q.push_back('{a: a_addr, d: a_data});
            if (exp_b) exp_q.push_back('{a: b_addr, d: b_data});
            mcount = mcount + int'(exp_a) + int'(exp_b) - ((mcount > 0) ? 1 : 0);
            tick();
        end
        idle_inputs();
        repeat (6) tick();
        tests_run++; if (log_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL b2b_count: got %0d writes expected %0d", log_q.size(), exp_q.size()); end
        for (int j = 0; j < exp_q.size() && j < log_q.size(); j++) begin
            tests_run++;
            if (log_q[j].a !== exp_q[j].a || log_q[j].d !== exp_q[j].d) begin
                tests_failed++;
                $display("FAIL b2b_order[%0d]: got R%0d=%h expected R%0d=%h", j, log_q[j].a, log_q[j].d, exp_q[j].a, exp_q[j].d);
            end
        end
    endtask

    task automatic test_r0_drop();
        log_q.delete();
        a_valid = 1'b1; a_addr = 3'd0; a_data = 16'hFFFF;
        #1;
        tests_run++; if (a_ready !== 1'b1) begin tests_failed++; $display("FAIL r0_ready: got %b expected 1", a_ready); end
        tick();
        idle_inputs();
        tests_run++; if (pending !== 8'h00) begin tests_failed++; $display("FAIL r0_pending: got %h expected 00", pending); end
        repeat (2) tick();
        tests_run++; if (log_q.size() != 0 || Wen !== 1'b0) begin tests_failed++; $display("FAIL r0_nowrite: got %0d writes wen=%b expected 0 0", log_q.size(), Wen); end
    endtask

    task automatic test_reset_mid_drain();
        a_valid = 1'b1; a_addr = 3'd1; a_data = 16'h0101;
        b_valid = 1'b1; b_addr = 3'd4; b_data = 16'h0404;
        tick();
        b_valid = 1'b0;
        a_addr = 3'd6; a_data = 16'h0606;
        tick();
        idle_inputs();
        tests_run++; if ({Wen, Wa} !== {1'b1, 3'd1}) begin tests_failed++; $display("FAIL mid_drain_active: got wen=%b wa=%0d expected 1 1", Wen, Wa); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (Wen !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_wen: got %b expected 0", Wen); end
        tests_run++; if (pending !== 8'h00) begin tests_failed++; $display("FAIL mid_reset_pending: got %h expected 00", pending); end
        @(negedge clk);
        rst_n = 1'b1;
        log_q.delete();
        repeat (5) tick();
        tests_run++; if (log_q.size() != 0) begin tests_failed++; $display("FAIL mid_residual: got %0d writes expected 0", log_q.size()); end
        tests_run++; if (pending !== 8'h00 || a_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_after: got pending=%h a_ready=%b expected 00 1", pending, a_ready); end
    endtask

    task automatic test_bypass();
        logic [15:0] exp_d1 [4];
        bit          exp_h1 [4];
        exp_h1 = '{1'b1, 1'b1, 1'b1, 1'b0};
        exp_d1 = '{16'h2222, 16'h2222, 16'h2222, 16'h0000};
        ra1 = 3'd5; ra2 = 3'd0;
        a_valid = 1'b1; a_addr = 3'd5; a_data = 16'h1111;
        b_valid = 1'b1; b_addr = 3'd5; b_data = 16'h2222;
        tick();
        idle_inputs();
        for (int s = 0; s < 4; s++) begin
            tests_run++;
            if (fwd1_hit !== (BYP & exp_h1[s]) || fwd1_data !== (BYP ? exp_d1[s] : 16'h0)) begin
                tests_failed++;
                $display("FAIL bypass_ra1[%0d]: got hit=%b data=%h expected %b %h", s, fwd1_hit, fwd1_data, BYP & exp_h1[s], BYP ? exp_d1[s] : 16'h0);
            end
            tests_run++;
            if (fwd2_hit !== 1'b0 || fwd2_data !== 16'h0) begin
                tests_failed++;
                $display("FAIL bypass_ra2[%0d]: got hit=%b data=%h expected 0 0000", s, fwd2_hit, fwd2_data);
            end
            tick();
        end
        tests_run++; if (regbank[5] !== 16'h2222) begin tests_failed++; $display("FAIL bypass_readback: got %h expected 2222", regbank[5]); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_same_cycle();
        test_back_to_back();
        test_r0_drop();
        test_reset_mid_drain();
        test_bypass();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
